instr_align: RTL and testbench
==============================

Name: instr_align

Overview:
- IA stage; consumes the fetched bundle (PC, two 16-bit halfwords, exception code, valid) produced by the IF stage.
- Emits exactly one aligned instruction per cycle to decode: 32-bit, or 16-bit compressed (RVC).
- Buffers one leftover halfword to handle:
  - two compressed instructions packed in one fetch word;
  - a 32-bit instruction straddling two fetch words;
  - odd-halfword PC entry.
- Back-pressures IF through o_stall.

Parameters:
- EXCEPT_W, 4, width of exception code field (shared package constant).
- XLEN, 32, PC and instruction width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_flush  in  1  pipeline redirect; drop all buffered state.
- i_stall  in  1  downstream stall; hold output and state.
- i_data  in  fetched_data_t  fetched bundle from IF. Fields:
  - valid 1
  - pc 32
  - data0 16 (low halfword)
  - data1 16 (high halfword)
  - except EXCEPT_W
- o_stall  out  1  stall to IF. While high, IF holds i_data and it is not consumed.
- o_data  out  aligned_instr_t  instruction to decode. Fields:
  - valid 1
  - pc 32
  - instr 32 (compressed: upper 16 bits zero)
  - is_rvc 1
  - except EXCEPT_W

Behaviour:
- Reset (async): o_data = all zero (valid 0, except EXCEPT_NONE); state EMPTY; held halfword and held_pc zero.
- Output is registered: instruction produced from input consumed in cycle N appears on o_data in cycle N+1.
- A halfword h is compressed iff h[1:0] != 2'b11.
- o_stall = i_stall | (state == PEND_C). This is combinational and has no dependency on i_data.
- Priority: i_rst > i_flush > i_stall > normal.
  - Flush: next o_data.valid = 0, state EMPTY; this holds even while i_stall is high.
  - Stall: o_data, state, and buffer all hold.
- States:
  - EMPTY: nothing buffered.
  - HALF: buffer holds the low half of a 32-bit instruction at held_pc.
  - PEND_C: buffer holds a complete compressed instruction at held_pc.
- EMPTY, i_data.valid = 0: o_data.valid = 0, stay.
- EMPTY, valid, except != NONE: emit {valid, pc, instr 0, except}; stay EMPTY.
- EMPTY, valid, pc[1] = 0, data0 compressed: emit RVC data0 at pc. Then:
  - data1 compressed → PEND_C, held = data1, held_pc = pc+2;
  - otherwise → HALF, held = data1, held_pc = pc+2.
- EMPTY, valid, pc[1] = 0, data0 not compressed: emit {data1, data0} at pc, 32-bit; stay EMPTY.
- EMPTY, valid, pc[1] = 1: data0 is ignored. Then:
  - data1 compressed → emit RVC at pc, stay EMPTY;
  - otherwise → HALF, held = data1, held_pc = pc, o_data.valid = 0.
- HALF, i_data.valid = 0: o_data.valid = 0, hold.
- HALF, valid, except != NONE: emit exception at held_pc; go EMPTY.
- HALF, valid: emit {data0, held} at held_pc, 32-bit. Then data1 is classified:
  - compressed → PEND_C at pc+2;
  - otherwise → HALF at pc+2.
- Sequential PC in HALF: i_data.pc == held_pc+2 (aligned) is guaranteed by IF. Non-sequential PCs arrive only after i_flush. A mismatch is not checked.
- PEND_C: emit RVC held at held_pc; go EMPTY. i_data is not consumed in this cycle.
- PC arithmetic is 32-bit modulo; held_pc+2 wraps at 0xFFFFFFFE → 0x00000000.

Decomposition:
- Package: fetched_data_t, aligned_instr_t, EXCEPT_* constants, align state enum.
- One natural sub-module: rvc_detect (halfword → is_rvc), shared with decode.

Test Plan:
- pc 0x1000, data0 0x4501, data1 0x4585 → cycle1 RVC 0x4501 @0x1000; o_stall high one cycle; cycle2 RVC 0x4585 @0x1002.
- pc 0x2000, data0 0x0513, data1 0x0000 → one 32-bit instr 0x00000513 @0x2000, is_rvc 0, no stall.
- pc 0x3000, data0 0x4501, data1 0x0513; next word pc 0x3004, data0 0x0010, data1 0x4505:
  - RVC 0x4501 @0x3000;
  - 32-bit 0x00100513 @0x3002;
  - RVC 0x4505 @0x3006.
- pc 0x4002, data1 0x0513, then pc 0x4004 with data0 0x0000 → 32-bit 0x00000513 @0x4002, one bubble first.
- State HALF, then i_flush; next cycle o_data.valid 0, state EMPTY. Repeat with i_stall high during flush and confirm the same result.
- HALF @0x5002, next input except = page-fault → o_data.except page-fault, pc 0x5002.
- Reset asserted mid-PEND_C → o_data zero and o_stall low immediately, with no clock edge.

Source files
------------

// File: rtl/instr_align_pkg.sv
// Shared types for the instruction-align stage: fetch bundle, aligned instruction,
// exception codes and the alignment buffer state.
package instr_align_pkg;

    localparam int EXCEPT_W = 4;
    localparam int XLEN     = 32;

    localparam logic [EXCEPT_W-1:0] EXCEPT_NONE         = 4'h0;
    localparam logic [EXCEPT_W-1:0] EXCEPT_ACCESS_FAULT = 4'h1;
    localparam logic [EXCEPT_W-1:0] EXCEPT_PAGE_FAULT   = 4'hC;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [15:0]         data0;
        logic [15:0]         data1;
        logic [EXCEPT_W-1:0] except;
    } fetched_data_t;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     instr;
        logic                is_rvc;
        logic [EXCEPT_W-1:0] except;
    } aligned_instr_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HALF   = 2'd1,
        ST_PEND_C = 2'd2
    } align_state_t;

    function automatic aligned_instr_t mk_rvc(input logic [XLEN-1:0] pc, input logic [15:0] hw);
        aligned_instr_t r;
        r.valid  = 1'b1;
        r.pc     = pc;
        r.instr  = {16'h0000, hw};
        r.is_rvc = 1'b1;
        r.except = EXCEPT_NONE;
        return r;
    endfunction

    function automatic aligned_instr_t mk_full(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] word);
        aligned_instr_t r;
        r.valid  = 1'b1;
        r.pc     = pc;
        r.instr  = word;
        r.is_rvc = 1'b0;
        r.except = EXCEPT_NONE;
        return r;
    endfunction

    function automatic aligned_instr_t mk_exc(input logic [XLEN-1:0] pc, input logic [EXCEPT_W-1:0] code);
        aligned_instr_t r;
        r.valid  = 1'b1;
        r.pc     = pc;
        r.instr  = '0;
        r.is_rvc = 1'b0;
        r.except = code;
        return r;
    endfunction

endpackage

// File: rtl/instr_align_rvc_detect.sv
// Classifies one halfword as a compressed (RVC) instruction parcel; pure combinational.
module rvc_detect (
    input  logic [15:0] halfword,
    output logic        is_rvc
);

    assign is_rvc = (halfword[1:0] != 2'b11);

endmodule

// File: rtl/instr_align.sv
// Aligns fetched halfword pairs into one 32-bit or RVC instruction per cycle; registered output, 1-cycle latency.
// Stalls IF while a buffered compressed instruction drains or decode stalls; flush drops the buffer.
module instr_align
    import instr_align_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_flush,
    input  logic           i_stall,
    input  fetched_data_t  i_data,
    output logic           o_stall,
    output aligned_instr_t o_data
);

    align_state_t    state, state_nxt;
    logic [15:0]     held, held_nxt;
    logic [XLEN-1:0] held_pc, held_pc_nxt;
    aligned_instr_t  out_nxt;
    logic            d0_rvc, d1_rvc;
    logic [XLEN-1:0] pc_plus2;

    rvc_detect u_rvc_d0 (
        .halfword (i_data.data0),
        .is_rvc   (d0_rvc)
    );

    rvc_detect u_rvc_d1 (
        .halfword (i_data.data1),
        .is_rvc   (d1_rvc)
    );

    assign pc_plus2 = i_data.pc + 32'd2;

    // The PEND_C drain cycle never looks at i_data, so this stall has no path from it.
    assign o_stall = i_stall | (state == ST_PEND_C);

    always_comb begin
        state_nxt   = state;
        held_nxt    = held;
        held_pc_nxt = held_pc;
        out_nxt     = o_data;
        if (i_flush) begin
            state_nxt   = ST_EMPTY;
            held_nxt    = '0;
            held_pc_nxt = '0;
            out_nxt     = '0;
        end else if (!i_stall) begin
            out_nxt = '0;
            unique case (state)
                ST_EMPTY: begin
                    if (i_data.valid) begin
                        if (i_data.except != EXCEPT_NONE) begin
                            out_nxt = mk_exc(i_data.pc, i_data.except);
                        end else if (!i_data.pc[1]) begin
                            if (d0_rvc) begin
                                out_nxt     = mk_rvc(i_data.pc, i_data.data0);
                                held_nxt    = i_data.data1;
                                held_pc_nxt = pc_plus2;
                                state_nxt   = d1_rvc ? ST_PEND_C : ST_HALF;
                            end else begin
                                out_nxt = mk_full(i_data.pc, {i_data.data1, i_data.data0});
                            end
                        end else if (d1_rvc) begin
                            out_nxt = mk_rvc(i_data.pc, i_data.data1);
                        end else begin
                            // Odd-halfword entry: data0 belongs to the previous word.
                            held_nxt    = i_data.data1;
                            held_pc_nxt = i_data.pc;
                            state_nxt   = ST_HALF;
                        end
                    end
                end
                ST_HALF: begin
                    if (i_data.valid) begin
                        if (i_data.except != EXCEPT_NONE) begin
                            out_nxt   = mk_exc(held_pc, i_data.except);
                            state_nxt = ST_EMPTY;
                        end else begin
                            out_nxt     = mk_full(held_pc, {i_data.data0, held});
                            held_nxt    = i_data.data1;
                            held_pc_nxt = pc_plus2;
                            state_nxt   = d1_rvc ? ST_PEND_C : ST_HALF;
                        end
                    end
                end
                ST_PEND_C: begin
                    out_nxt   = mk_rvc(held_pc, held);
                    state_nxt = ST_EMPTY;
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_EMPTY;
            held    <= '0;
            held_pc <= '0;
            o_data  <= '0;
        end else begin
            state   <= state_nxt;
            held    <= held_nxt;
            held_pc <= held_pc_nxt;
            o_data  <= out_nxt;
        end
    end

endmodule

// File: tb/tb_instr_align.sv
// Directed checks of alignment cases plus randomized instruction streams scored against a program-level model.
module tb_instr_align;
    import instr_align_pkg::*;

    logic           i_clk;
    logic           i_rst;
    logic           i_flush;
    logic           i_stall;
    fetched_data_t  i_data;
    logic           o_stall;
    aligned_instr_t o_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rvc;
    } exp_t;

    exp_t          expq[$];
    fetched_data_t words[$];

    instr_align dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_stall (i_stall),
        .i_data  (i_data),
        .o_stall (o_stall),
        .o_data  (o_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic rvc, input logic [EXCEPT_W-1:0] exc);
        chk({tag, ".valid"},  64'(o_data.valid),  64'd1);
        chk({tag, ".pc"},     64'(o_data.pc),     64'(pc));
        chk({tag, ".instr"},  64'(o_data.instr),  64'(instr));
        chk({tag, ".is_rvc"}, 64'(o_data.is_rvc), 64'(rvc));
        chk({tag, ".except"}, 64'(o_data.except), 64'(exc));
    endtask

    function automatic fetched_data_t fw(input logic [31:0] pc, input logic [15:0] d0,
                                         input logic [15:0] d1, input logic [EXCEPT_W-1:0] exc);
        fetched_data_t f;
        f.valid  = 1'b1;
        f.pc     = pc;
        f.data0  = d0;
        f.data1  = d1;
        f.except = exc;
        return f;
    endfunction

    // One clock: drive at the falling edge, observe 1 time unit after the rising edge.
    task automatic cyc(input fetched_data_t d, input logic st, input logic fl);
        @(negedge i_clk);
        i_data  = d;
        i_stall = st;
        i_flush = fl;
        @(posedge i_clk);
        #1;
    endtask

    // Lays out a random program as halfwords and splits it into fetch words.
    task automatic build(input logic [31:0] start, input int n_ins);
        logic [15:0] hw[$];
        logic [15:0] h, lo, hi;
        logic [31:0] pc, base;
        pc = start;
        if (start[1]) hw.push_back(16'($urandom));
        for (int i = 0; i < n_ins; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                h = 16'($urandom);
                h[1:0] = 2'($urandom_range(0, 2));
                hw.push_back(h);
                expq.push_back('{pc: pc, instr: {16'h0000, h}, rvc: 1'b1});
                pc = pc + 32'd2;
            end else begin
                lo = 16'($urandom);
                lo[1:0] = 2'b11;
                hi = 16'($urandom);
                hw.push_back(lo);
                hw.push_back(hi);
                expq.push_back('{pc: pc, instr: {hi, lo}, rvc: 1'b0});
                pc = pc + 32'd4;
            end
        end
        if (hw.size() % 2 == 1) begin
            hw.push_back(16'h0001);
            expq.push_back('{pc: pc, instr: 32'h0000_0001, rvc: 1'b1});
        end
        base = {start[31:2], 2'b00};
        for (int k = 0; k < hw.size() / 2; k++)
            words.push_back(fw((k == 0) ? start : base + 32'(4 * k), hw[2*k], hw[2*k+1], EXCEPT_NONE));
    endtask

    task automatic run_stream(input string tag);
        int   widx;
        logic taken;
        logic keep;
        exp_t e;
        widx  = 0;
        taken = 1'b0;
        for (int c = 0; c < 4000 && (widx < words.size() || expq.size() > 0); c++) begin
            @(negedge i_clk);
            if (taken) widx++;
            keep    = i_data.valid && !taken;
            i_stall = ($urandom_range(0, 3) == 0);
            i_flush = 1'b0;
            if (widx < words.size() && (keep || $urandom_range(0, 3) != 0)) i_data = words[widx];
            else i_data = '0;
            #1;
            taken = i_data.valid && !o_stall;
            if (o_data.valid && !i_stall) begin
                if (expq.size() == 0) begin
                    chk({tag, ".extra_output"}, 64'(o_data.pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk({tag, ".pc"},     64'(o_data.pc),     64'(e.pc));
                    chk({tag, ".instr"},  64'(o_data.instr),  64'(e.instr));
                    chk({tag, ".is_rvc"}, 64'(o_data.is_rvc), 64'(e.rvc));
                    chk({tag, ".except"}, 64'(o_data.except), 64'(EXCEPT_NONE));
                end
            end
        end
        if (taken) widx++;
        chk({tag, ".leftover"}, 64'(expq.size() + (words.size() - widx)), 64'd0);
        @(negedge i_clk);
        i_data  = '0;
        i_stall = 1'b0;
        expq.delete();
        words.delete();
    endtask

    initial begin
        fetched_data_t idle;
        idle    = '0;
        i_rst   = 1'b1;
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_data  = '0;
        #1;
        chk("reset.o_data", 64'(o_data), 64'd0);
        chk("reset.o_stall", 64'(o_stall), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Two RVC in one word; IF stalled for one cycle while the second drains.
        cyc(fw(32'h1000, 16'h4501, 16'h4585, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("pair.first", 32'h1000, 32'h0000_4501, 1'b1, EXCEPT_NONE);
        chk("pair.stall_hi", 64'(o_stall), 64'd1);
        cyc(idle, 1'b0, 1'b0);
        chk_out("pair.second", 32'h1002, 32'h0000_4585, 1'b1, EXCEPT_NONE);
        chk("pair.stall_lo", 64'(o_stall), 64'd0);

        cyc(fw(32'h2000, 16'h0513, 16'h0000, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("full32", 32'h2000, 32'h0000_0513, 1'b0, EXCEPT_NONE);
        chk("full32.stall", 64'(o_stall), 64'd0);

        // RVC, straddling 32-bit, trailing RVC.
        cyc(fw(32'h3000, 16'h4501, 16'h0513, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("straddle.rvc0", 32'h3000, 32'h0000_4501, 1'b1, EXCEPT_NONE);
        cyc(fw(32'h3004, 16'h0010, 16'h4505, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("straddle.w32", 32'h3002, 32'h0010_0513, 1'b0, EXCEPT_NONE);
        cyc(idle, 1'b0, 1'b0);
        chk_out("straddle.rvc1", 32'h3006, 32'h0000_4505, 1'b1, EXCEPT_NONE);

        // Odd-halfword entry: one bubble, then the assembled 32-bit instruction.
        cyc(fw(32'h4002, 16'h4501, 16'h0513, EXCEPT_NONE), 1'b0, 1'b0);
        chk("odd.bubble", 64'(o_data.valid), 64'd0);
        cyc(fw(32'h4004, 16'h0000, 16'h0001, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("odd.w32", 32'h4002, 32'h0000_0513, 1'b0, EXCEPT_NONE);
        cyc(idle, 1'b0, 1'b0);
        chk_out("odd.tail", 32'h4006, 32'h0000_0001, 1'b1, EXCEPT_NONE);

        // Stall holds output and state; the held word is consumed on release.
        cyc(fw(32'h8000, 16'h0513, 16'h0000, EXCEPT_NONE), 1'b0, 1'b0);
        cyc(fw(32'h8004, 16'h4501, 16'h0513, EXCEPT_NONE), 1'b1, 1'b0);
        chk_out("stall.hold", 32'h8000, 32'h0000_0513, 1'b0, EXCEPT_NONE);
        chk("stall.o_stall", 64'(o_stall), 64'd1);
        cyc(fw(32'h8004, 16'h4501, 16'h0513, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("stall.release", 32'h8004, 32'h0000_4501, 1'b1, EXCEPT_NONE);
        cyc(fw(32'h8008, 16'h0000, 16'h0001, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("stall.after", 32'h8006, 32'h0000_0513, 1'b0, EXCEPT_NONE);
        cyc(idle, 1'b0, 1'b0);

        // Flush from HALF drops the buffered halfword.
        cyc(fw(32'h6002, 16'h0000, 16'h0513, EXCEPT_NONE), 1'b0, 1'b0);
        cyc(idle, 1'b0, 1'b1);
        chk("flush.valid", 64'(o_data.valid), 64'd0);
        chk("flush.o_stall", 64'(o_stall), 64'd0);
        cyc(fw(32'h7000, 16'h0513, 16'h0000, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("flush.empty", 32'h7000, 32'h0000_0513, 1'b0, EXCEPT_NONE);

        // Flush wins over a simultaneous stall.
        cyc(fw(32'h6000, 16'h4501, 16'h0513, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("flushst.pre", 32'h6000, 32'h0000_4501, 1'b1, EXCEPT_NONE);
        cyc(idle, 1'b1, 1'b1);
        chk("flushst.valid", 64'(o_data.valid), 64'd0);
        cyc(fw(32'h7000, 16'h0513, 16'h0000, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("flushst.empty", 32'h7000, 32'h0000_0513, 1'b0, EXCEPT_NONE);

        // Exception on the second half of a straddling instruction.
        cyc(fw(32'h5002, 16'h0000, 16'h0513, EXCEPT_NONE), 1'b0, 1'b0);
        chk("pf.bubble", 64'(o_data.valid), 64'd0);
        cyc(fw(32'h5004, 16'h0000, 16'h0000, EXCEPT_PAGE_FAULT), 1'b0, 1'b0);
        chk_out("pf", 32'h5002, 32'h0000_0000, 1'b0, EXCEPT_PAGE_FAULT);
        cyc(fw(32'h7100, 16'h0513, 16'h0000, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("pf.empty_after", 32'h7100, 32'h0000_0513, 1'b0, EXCEPT_NONE);

        // Exception taken directly in EMPTY.
        cyc(fw(32'h7200, 16'h4501, 16'h4585, EXCEPT_ACCESS_FAULT), 1'b0, 1'b0);
        chk_out("af.empty", 32'h7200, 32'h0000_0000, 1'b0, EXCEPT_ACCESS_FAULT);
        chk("af.no_pend", 64'(o_stall), 64'd0);

        // held_pc + 2 wraps through zero.
        cyc(fw(32'hFFFF_FFFE, 16'h0000, 16'h0513, EXCEPT_NONE), 1'b0, 1'b0);
        cyc(fw(32'h0000_0000, 16'h0000, 16'h4505, EXCEPT_NONE), 1'b0, 1'b0);
        chk_out("wrap.w32", 32'hFFFF_FFFE, 32'h0000_0513, 1'b0, EXCEPT_NONE);
        cyc(idle, 1'b0, 1'b0);
        chk_out("wrap.rvc", 32'h0000_0002, 32'h0000_4505, 1'b1, EXCEPT_NONE);

        // Asynchronous reset while a compressed instruction is pending.
        cyc(fw(32'h1000, 16'h4501, 16'h4585, EXCEPT_NONE), 1'b0, 1'b0);
        chk("arst.pend", 64'(o_stall), 64'd1);
        i_data = idle;
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst.o_data", 64'(o_data), 64'd0);
        chk("arst.o_stall", 64'(o_stall), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        build(32'h0001_0000 + 32'(2 * $urandom_range(0, 1)), 40);
        run_stream("rand_a");
        build(32'hFFFF_FFF2, 20);
        run_stream("rand_wrap");
        build({$urandom_range(0, 32'h3FFF_FFFF), 2'b00} + 32'(2 * $urandom_range(0, 1)), 60);
        run_stream("rand_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
